// File: rtl/sine_dac_serializer.sv
// Converts two's-complement sine samples to offset binary and streams them MSB first
// to an SPI-style DAC through a one-entry, latest-wins holding buffer.
module sine_dac_serializer #(
   parameter int CLK_DIV  = 4,
   parameter int DAC_BITS = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] sample,
   input  logic        sample_valid,
   output logic        sample_ready,
   output logic        dac_sclk,
   output logic        dac_mosi,
   output logic        dac_cs_n,
   output logic        busy,
   output logic [7:0]  overrun_cnt
);

   localparam int            HW        = $clog2(2 * DAC_BITS);
   localparam logic [7:0]    DIV_M1    = 8'(CLK_DIV - 1);
   localparam logic [HW-1:0] LAST_HALF = HW'(2 * DAC_BITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [HW-1:0]       half_q, half_d;
   logic [DAC_BITS-1:0] shreg_q, shreg_d;
   logic [DAC_BITS-1:0] buf_q, buf_d;
   logic                buf_full_q, buf_full_d;
   logic                sclk_q, sclk_d;
   logic                mosi_q, mosi_d;
   logic                cs_n_q, cs_n_d;
   logic                busy_q, busy_d;
   logic                ready_q, ready_d;
   logic [7:0]          ovr_q, ovr_d;
   logic                load_s;
   logic [DAC_BITS-1:0] word_s;
   logic                unused_lsbs_s;

   // Offset binary: flip the sign bit and keep the top DAC_BITS bits.
   assign word_s        = {~sample[31], sample[30:32-DAC_BITS]};
   assign unused_lsbs_s = ^sample[31-DAC_BITS:0];

   // Frame sequencer and holding-buffer next-state logic.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      half_d     = half_q;
      shreg_d    = shreg_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      cs_n_d     = cs_n_q;
      ovr_d      = ovr_q;
      load_s     = 1'b0;

      case (state_q)
         IDLE: begin
            if (buf_full_q) begin
               load_s  = 1'b1;
               shreg_d = buf_q;
               cs_n_d  = 1'b0;
               mosi_d  = buf_q[DAC_BITS-1];
               cnt_d   = DIV_M1;
               state_d = SETUP;
            end else begin
               state_d = IDLE;
            end
         end
         SETUP: begin
            if (cnt_q == 8'd0) begin
               cnt_d   = DIV_M1;
               half_d  = {HW{1'b0}};
               state_d = SHIFT;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         SHIFT: begin
            if (cnt_q == 8'd0) begin
               cnt_d  = DIV_M1;
               half_d = half_q + {{(HW-1){1'b0}}, 1'b1};
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else if (half_q == LAST_HALF) begin
                  sclk_d  = 1'b0;
                  cs_n_d  = 1'b1;
                  mosi_d  = 1'b0;
                  state_d = HOLD;
               end else begin
                  // Falling edge: present the next bit for the DAC's rising-edge sample.
                  sclk_d  = 1'b0;
                  mosi_d  = shreg_q[DAC_BITS-2];
                  shreg_d = shreg_q << 1;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         HOLD: begin
            if (cnt_q == 8'd0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A write arriving with a load lands in the just-emptied buffer, so no overrun.
      if (sample_valid) begin
         buf_d      = word_s;
         buf_full_d = 1'b1;
         if (buf_full_q && !load_s && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
         end else begin
            ovr_d = ovr_q;
         end
      end else if (load_s) begin
         buf_full_d = 1'b0;
      end else begin
         buf_full_d = buf_full_q;
      end

      busy_d  = (state_d != IDLE);
      ready_d = ~buf_full_d;
   end

   // State and output registers; reset aborts any frame in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= 8'd0;
         half_q     <= {HW{1'b0}};
         shreg_q    <= {DAC_BITS{1'b0}};
         buf_q      <= {DAC_BITS{1'b0}};
         buf_full_q <= 1'b0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         busy_q     <= 1'b0;
         ready_q    <= 1'b1;
         ovr_q      <= 8'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         half_q     <= half_d;
         shreg_q    <= shreg_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         cs_n_q     <= cs_n_d;
         busy_q     <= busy_d;
         ready_q    <= ready_d;
         ovr_q      <= ovr_d;
      end
   end

   assign sample_ready = ready_q;
   assign dac_sclk     = sclk_q;
   assign dac_mosi     = mosi_q;
   assign dac_cs_n     = cs_n_q;
   assign busy         = busy_q;
   assign overrun_cnt  = ovr_q;

endmodule

// File: tb/tb_sine_dac_serializer.sv
// Scoreboard bench: a CLK_DIV=4 and a CLK_DIV=1 instance checked against a
// transaction-level model of the buffer, frame timing and overrun counter.
module tb_sine_dac_serializer;

   localparam int B = 16;
   localparam int DIVS [2] = '{4, 1};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n = 1'b0;
   logic              sv4 = 1'b0, sv1 = 1'b0;
   logic [31:0]       smp4 = 32'd0, smp1 = 32'd0;
   logic              d1_done = 1'b0;
   logic [1:0]        rdy_w, sclk_w, mosi_w, csn_w, busy_w;
   logic [1:0][7:0]   ovr_w;
   logic [1:0]        v_w;
   logic [1:0][31:0]  smp_w;

   assign v_w   = {sv1, sv4};
   assign smp_w = {smp1, smp4};

   sine_dac_serializer #(.CLK_DIV(4), .DAC_BITS(B)) u_d4 (
      .clk(clk), .rst_n(rst_n), .sample(smp4), .sample_valid(sv4),
      .sample_ready(rdy_w[0]), .dac_sclk(sclk_w[0]), .dac_mosi(mosi_w[0]),
      .dac_cs_n(csn_w[0]), .busy(busy_w[0]), .overrun_cnt(ovr_w[0]));

   sine_dac_serializer #(.CLK_DIV(1), .DAC_BITS(B)) u_d1 (
      .clk(clk), .rst_n(rst_n), .sample(smp1), .sample_valid(sv1),
      .sample_ready(rdy_w[1]), .dac_sclk(sclk_w[1]), .dac_mosi(mosi_w[1]),
      .dac_cs_n(csn_w[1]), .busy(busy_w[1]), .overrun_cnt(ovr_w[1]));

   // Counters and scoreboard state, all owned by the single model/monitor process.
   int          n_cmp = 0, n_bad = 0, cyc = 0;
   logic [15:0] expq [2][$];
   bit          m_full [2];
   logic [15:0] m_word [2];
   int          m_next [2], m_busy_end [2], m_ovr [2];
   bit          in_frame [2];
   logic [15:0] bits [2];
   int          nb [2], low [2], last_fall [2];
   logic        p_cs [2], p_sclk [2];

   // Directed checks requested by the stimulus process.
   int    dchk_req = 0, dchk_seen = 0, dchk_act = 0, dchk_exp = 0;
   string dchk_name = "";

   function automatic logic [15:0] conv(input logic [31:0] s);
      int unsigned top;
      top = s >> 16;
      return 16'((top + 32768) % 65536);
   endfunction

   task automatic chk(input string nm, input int inst, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s (inst %0d): got 0x%0h, expected 0x%0h", nm, inst, act, exp);
      end
   endtask

   always begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_full[i] = 1'b0; m_next[i] = 0; m_busy_end[i] = 0; m_ovr[i] = 0;
            expq[i].delete();
         end else begin
            bit ld;
            ld = m_full[i] && (cyc >= m_next[i]);
            if (ld) begin
               expq[i].push_back(m_word[i]);
               m_next[i]     = cyc + (2 * B + 2) * DIVS[i] + 1;
               m_busy_end[i] = cyc + (2 * B + 2) * DIVS[i];
            end
            if (v_w[i]) begin
               if (m_full[i] && !ld && m_ovr[i] < 255) m_ovr[i]++;
               m_word[i] = conv(smp_w[i]);
               m_full[i] = 1'b1;
            end else if (ld) begin
               m_full[i] = 1'b0;
            end
         end
      end

      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            in_frame[i] = 1'b0; p_cs[i] = 1'b1; p_sclk[i] = 1'b0; last_fall[i] = -1;
         end else begin
            if (p_cs[i] && !csn_w[i]) begin
               in_frame[i] = 1'b1; bits[i] = 16'd0; nb[i] = 0; low[i] = 0;
               if (i == 1 && last_fall[i] >= 0) chk("frame_period", i, cyc - last_fall[i], 35);
               last_fall[i] = cyc;
            end
            if (!csn_w[i] && in_frame[i]) begin
               low[i]++;
               if (sclk_w[i] && !p_sclk[i]) begin
                  bits[i] = {bits[i][14:0], mosi_w[i]};
                  nb[i]++;
               end
            end
            if (!p_cs[i] && csn_w[i] && in_frame[i]) begin
               if (expq[i].size() == 0) begin
                  chk("frame_unexpected", i, 1, 0);
               end else begin
                  chk("frame_word", i, bits[i], expq[i].pop_front());
               end
               chk("frame_bits", i, nb[i], B);
               chk("cs_low_cycles", i, low[i], (2 * B + 1) * DIVS[i]);
               in_frame[i] = 1'b0;
            end
            chk("overrun_cnt", i, ovr_w[i], m_ovr[i]);
            chk("sample_ready", i, rdy_w[i], !m_full[i]);
            chk("busy", i, busy_w[i], cyc < m_busy_end[i]);
            p_cs[i] = csn_w[i]; p_sclk[i] = sclk_w[i];
         end
      end
      if (dchk_req != dchk_seen) begin
         chk(dchk_name, 0, dchk_act, dchk_exp);
         dchk_seen = dchk_req;
      end
   end

   task automatic post(input string nm, input int act, input int exp);
      dchk_name = nm; dchk_act = act; dchk_exp = exp;
      dchk_req++;
      @(negedge clk);
      #1;
   endtask

   task automatic send4(input logic [31:0] v);
      @(posedge clk);
      #1; sv4 = 1'b1; smp4 = v;
      @(posedge clk);
      #1; sv4 = 1'b0;
   endtask

   task automatic wait_idle4();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy_w[0] || !rdy_w[0]) && n < 1000);
      #1;
      if (n >= 1000) post("idle_timeout", 1, 0);
   endtask

   // CLK_DIV=1 instance: a strobe on every cycle.
   initial begin
      repeat (4) @(posedge clk);
      #1; sv1 = 1'b1;
      for (int k = 0; k < 500; k++) begin
         smp1 = $urandom;
         @(posedge clk);
         #1;
      end
      sv1 = 1'b0;
      repeat (100) @(posedge clk);
      d1_done = 1'b1;
   end

   initial begin
      logic [31:0] dir [3];
      int n, r, a_cs, a_sclk;
      logic p;
      dir = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_1234};

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk); #1;
      post("rst_ready", rdy_w[0], 1);
      post("rst_sclk", sclk_w[0], 0);
      post("rst_mosi", mosi_w[0], 0);
      post("rst_cs_n", csn_w[0], 1);
      post("rst_busy", busy_w[0], 0);
      post("rst_overrun", ovr_w[0], 0);

      send4(32'h0000_0000);
      n = 0;
      do begin
         @(posedge clk); n++;
         @(negedge clk);
      end while (busy_w[0] && n < 300);
      #1;
      post("busy_fall_latency", n, 137);
      wait_idle4();

      foreach (dir[k]) begin
         send4(dir[k]);
         wait_idle4();
      end

      send4(32'h1000_0000);
      repeat (20) @(posedge clk);
      send4(32'h2000_0000);
      repeat (20) @(posedge clk);
      send4(32'h3000_0000);
      wait_idle4();
      post("overrun_three", ovr_w[0], 1);

      n = 0;
      while (!d1_done && n < 5000) begin
         @(posedge clk); n++;
      end
      #1;
      if (!d1_done) post("d1_timeout", 0, 1);

      send4($urandom);
      r = 0; p = 1'b0; n = 0;
      while (r < 7 && n < 500) begin
         @(negedge clk); n++;
         if (sclk_w[0] && !p) r++;
         p = sclk_w[0];
      end
      rst_n = 1'b0;
      #1;
      a_cs = csn_w[0]; a_sclk = sclk_w[0];
      post("seventh_rise", r, 7);
      post("abort_cs_n", a_cs, 1);
      post("abort_sclk", a_sclk, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      post("post_rst_busy", busy_w[0], 0);
      send4($urandom);
      wait_idle4();

      for (int k = 0; k < 250; k++) begin
         send4($urandom);
         repeat ((k % 8 == 7) ? 200 : $urandom_range(1, 40)) @(posedge clk);
      end
      wait_idle4();

      for (int k = 0; k < 500; k++) begin
         send4($urandom);
         repeat (98) @(posedge clk);
      end
      wait_idle4();
      post("overrun_saturated", ovr_w[0], 255);

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
